shift_unit_mc: RTL and testbench
================================

# shift_unit_mc

Multi-cycle shift unit for the RISC-V datapath. Performs the SLL/SRL/SRA family (R-type and immediate forms) on a register operand. It sits between register-file read and the result/writeback mux: the decoder raises `start` with rs1 and shamt (rs2[4:0] or imm[4:0]), and the control FSM stalls the PC until `done`. It trades the single-cycle barrel shifter for an iterative one shifting `STEP` bits per cycle, so the FPGA build can meet timing on slow parts.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `STEP`, 1, bits shifted per RUN cycle; power of two, 1..32.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on rising edge in IDLE or DONE only.
- `op`  in  2  shift kind: 0 = SLL, 1 = SRL, 2 = SRA, 3 = pass (no shift).
- `a`  in  32  operand (rs1); sampled on the accept edge only.
- `shamt`  in  5  shift amount, unsigned 0..31; sampled on the accept edge only.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `result` valid while high.
- `result`  out  32  shifted value.

## Operation
- **Registers:**
  - `state` ∈ {IDLE, RUN, DONE}
  - `acc[31:0]`
  - `rem[5:0]`
  - `kind[1:0]`
  - `result` = `acc`.
- **Accept:** happens on an edge where `start`=1 and `state` is IDLE or DONE.
  - Load `acc`=`a`, `kind`=`op`.
  - Load `rem`=`shamt`, or 0 when `op`=3.
  - Next state is DONE if the loaded `rem`==0, otherwise RUN.
- **RUN edge:** let `k` = min(`STEP`, `rem`).
  - SLL: `acc` <<= `k`, zero fill.
  - SRL: `acc` >>= `k`, zero fill.
  - SRA: `acc` >>= `k`, filled with `acc[31]`. The sign is preserved because `acc[31]` never changes during SRA.
  - `rem` -= `k`; next state is DONE if the new `rem`==0, else stay in RUN.
- **DONE:**
  - `done`=1 for exactly one cycle.
  - Next state is RUN/DONE if a new request is accepted on that edge, else IDLE.
- **IDLE:** hold all registers.
  - Accepted `start` → RUN/DONE as above.
- **`start` while RUN:** ignored. The request is not queued; the requester must hold `start` until accepted.
- **`result`:**
  - Valid when `done`=1.
  - Holds its value through IDLE until the next accept edge.
  - Values during RUN are unspecified.
- **Outputs:** `busy` = (`state`==RUN), `done` = (`state`==DONE), both decoded from registered state with no combinational path from inputs.
- **Width rules:**
  - `shamt` is 5 bits, so shifts ≥ 32 are impossible.
  - `rem` is 6 bits for headroom.
  - `k` never exceeds `rem`, so there is no overshoot.

## Timing
- **Reset** (`rst`=0, asynchronous):
  - `state`=IDLE, `acc`=0, `rem`=0, `kind`=0.
  - Outputs: `busy`=0, `done`=0, `result`=0.
  - Release is synchronous to the next edge.
- **Latency:** with accept on edge E, `done` is high during the cycle following edge E + ceil(`shamt`/`STEP`).
  - `shamt`=0 or `op`=3: `done` in the cycle right after E.
  - `STEP`=1, `shamt`=31: 31 cycles later.
  - `STEP`=32: always after E+1, except `shamt`=0.
- **Back-to-back:** `start` high during the DONE cycle is accepted on the edge ending DONE, so there is no idle bubble. That `done` pulse still lasts exactly one cycle; `done` stays high into the next cycle only if the new request has zero latency. Throughput is one op per ceil(`shamt`/`STEP`)+1 cycles.
- **Reset mid-RUN:** aborts the operation, returns to IDLE, and produces no `done` pulse.
- **Input stability:** `a`/`shamt`/`op` may change freely after the accept edge without affecting the result.

## Test plan
- `STEP`=1, `a`=0x000000F0, `shamt`=4, `op`=SRL → `busy` for 4 cycles; `done` 4 edges after accept; `result`=0x0000000F.
- `STEP`=4, `a`=0x80000000, `shamt`=31, `op`=SRA → `done` 8 edges after accept; `result`=0xFFFFFFFF. Same with `op`=SRL → 0x00000001.
- `a`=0xDEADBEEF, `shamt`=0, `op`=SLL; then `op`=3 with `shamt`=7 → `done` in the cycle after accept, `result`=0xDEADBEEF, `busy` never high.
- SLL `a`=1, `shamt`=3 with `start` held high throughout (a new request presented in the DONE cycle: `a`=0x00000010, SRL by 4) → first `result`=8; second op accepted on the edge ending DONE; second `result`=0x00000001; no IDLE cycle between them.
- Pulse `start` with different `a`/`shamt` during RUN → ignored; the original result completes; `done` pulses once.
- Assert `rst`=0 asynchronously mid-RUN (between edges) → `busy`/`done`/`result` go to 0 immediately; no `done` after release; the next request completes normally.

Source files
------------

// File: rtl/shift_unit_mc.sv
// Iterative shift unit: SLL/SRL/SRA/pass on a 32-bit operand, STEP bits per cycle.
// Handshake is start -> busy while running -> one-cycle done with result held afterwards.
module shift_unit_mc #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'd0;
  localparam logic [1:0] OP_SRL  = 2'd1;
  localparam logic [1:0] OP_SRA  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;
  localparam logic [5:0] STEP_R  = 6'(STEP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [5:0]       rem, rem_nxt;
  logic [1:0]       kind, kind_nxt;
  logic [5:0]       k;
  logic [5:0]       load_rem;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acc   <= '0;
      rem   <= '0;
      kind  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      kind  <= kind_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    kind_nxt  = kind;
    k         = '0;
    accept    = start && (state == S_IDLE || state == S_DONE);
    load_rem  = (op == OP_PASS) ? 6'd0 : {1'b0, shamt};

    if (state == S_RUN) begin
      // Clamp the last step to what remains so the total never overshoots shamt.
      k = (rem < STEP_R) ? rem : STEP_R;
      unique case (kind)
        OP_SLL:  acc_nxt = acc << k;
        OP_SRL:  acc_nxt = acc >> k;
        OP_SRA:  acc_nxt = $signed(acc) >>> k;
        default: acc_nxt = acc;
      endcase
      rem_nxt   = rem - k;
      state_nxt = (rem_nxt == 6'd0) ? S_DONE : S_RUN;
    end else if (accept) begin
      acc_nxt   = a;
      kind_nxt  = op;
      rem_nxt   = load_rem;
      state_nxt = (load_rem == 6'd0) ? S_DONE : S_RUN;
    end else begin
      state_nxt = S_IDLE;
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = acc;

endmodule

// File: tb/tb_shift_unit_mc.sv
// Scoreboard bench for shift_unit_mc: one instance with STEP=1, one with STEP=4.
// Stimulus pushes expected (result, done-cycle) pairs; a monitor pops on every done.
module tb_shift_unit_mc;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_v  [2];
  logic [1:0]  op_v     [2];
  logic [31:0] a_v      [2];
  logic [4:0]  sh_v     [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [31:0] result_v [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   cyc;
  int   n_cmp;
  int   n_fail;

  shift_unit_mc #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]),
    .shamt(sh_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
  );

  shift_unit_mc #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .a(a_v[1]),
    .shamt(sh_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t qpop(int d);
    exp_t e;
    if (d == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    return e;
  endfunction

  function automatic int qfront_cyc(int d);
    return (d == 0) ? sb0[0].cyc : sb1[0].cyc;
  endfunction

  function automatic void monitor_dut(int d);
    exp_t e;
    if (!rst) begin
      check32($sformatf("reset_busy%0d", d), {31'd0, busy_v[d]}, 32'd0);
      check32($sformatf("reset_done%0d", d), {31'd0, done_v[d]}, 32'd0);
      check32($sformatf("reset_result%0d", d), result_v[d], 32'd0);
    end else if (done_v[d]) begin
      if (qsize(d) == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done%0d: done high at cycle %0d, no request pending", d, cyc);
      end else begin
        e = qpop(d);
        check32($sformatf("result%0d", d), result_v[d], e.res);
        check_int($sformatf("done_cycle%0d", d), cyc, e.cyc);
      end
    end else if (qsize(d) != 0 && qfront_cyc(d) < cyc) begin
      e = qpop(d);
      n_cmp++;
      n_fail++;
      $display("FAIL timeout%0d: no done by cycle %0d, required at cycle %0d", d, cyc, e.cyc);
    end
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    forever begin
      @(negedge clk);
      monitor_dut(0);
      monitor_dut(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int d, input logic [1:0] o, input logic [31:0] x,
                       input logic [4:0] s);
    start_v[d] = 1'b1;
    op_v[d]    = o;
    a_v[d]     = x;
    sh_v[d]    = s;
  endtask

  task automatic accept_edge(input int d, input logic [31:0] res, input int lat,
                             output int acc_cyc);
    exp_t e;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    e.res   = res;
    e.cyc   = cyc + lat;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200 && qsize(d) != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic single_op(input int d, input logic [1:0] o, input logic [31:0] x,
                           input logic [4:0] s, input logic [31:0] res, input int lat);
    int acc_cyc;
    drive(d, o, x, s);
    accept_edge(d, res, lat, acc_cyc);
    start_v[d] = 1'b0;
    a_v[d]     = ~x;
    sh_v[d]    = ~s;
    op_v[d]    = ~o;
    wait_idle(d);
  endtask

  task automatic back_to_back(input int d,
                              input logic [1:0] o1, input logic [31:0] x1, input logic [4:0] s1,
                              input logic [31:0] r1, input int lat1,
                              input logic [1:0] o2, input logic [31:0] x2, input logic [4:0] s2,
                              input logic [31:0] r2, input int lat2);
    int acc1, acc2;
    drive(d, o1, x1, s1);
    accept_edge(d, r1, lat1, acc1);
    repeat (lat1 + 1) @(negedge clk);
    drive(d, o2, x2, s2);
    accept_edge(d, r2, lat2, acc2);
    start_v[d] = 1'b0;
    wait_idle(d);
  endtask

  initial begin
    int acc_cyc;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      op_v[d]    = 2'd0;
      a_v[d]     = 32'd0;
      sh_v[d]    = 5'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // STEP=1 vectors
    single_op(0, 2'd1, 32'h0000_00F0, 5'd4,  32'h0000_000F, 4);
    single_op(0, 2'd2, 32'hF000_0000, 5'd4,  32'hFF00_0000, 4);
    single_op(0, 2'd3, 32'h1234_5678, 5'd9,  32'h1234_5678, 0);
    back_to_back(0, 2'd0, 32'h0000_0001, 5'd3, 32'h0000_0008, 3,
                    2'd1, 32'h0000_0010, 5'd4, 32'h0000_0001, 4);

    // start pulsed during RUN must be ignored
    drive(0, 2'd0, 32'h0000_0003, 5'd10);
    accept_edge(0, 32'h0000_0C00, 10, acc_cyc);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    drive(0, 2'd1, 32'hFFFF_FFFF, 5'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);

    // STEP=4 vectors
    single_op(1, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8);
    single_op(1, 2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 8);
    single_op(1, 2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
    single_op(1, 2'd3, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 0);
    single_op(1, 2'd2, 32'h7FFF_FFFF, 5'd5,  32'h03FF_FFFF, 2);
    single_op(1, 2'd0, 32'h1234_5678, 5'd8,  32'h3456_7800, 2);
    single_op(1, 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 8);
    single_op(1, 2'd1, 32'h0000_00F0, 5'd4,  32'h0000_000F, 1);
    back_to_back(1, 2'd0, 32'h0000_0001, 5'd3, 32'h0000_0008, 1,
                    2'd3, 32'h0000_0055, 5'd2, 32'h0000_0055, 0);

    // asynchronous reset mid-RUN, asserted between a rising and the next falling edge
    drive(0, 2'd1, 32'hFFFF_0000, 5'd20);
    accept_edge(0, 32'h0000_0FFF, 20, acc_cyc);
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    sb0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);

    single_op(0, 2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 31);
    single_op(1, 2'd2, 32'hC000_0000, 5'd6,  32'hFF00_0000, 2);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
